// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in/parallel-out receiver.
package sipo_pkg;

  // Default number of data bits per word.
  localparam int SIPO_WIDTH = 6;

  // Receive FSM states. PAR is reachable only when parity checking is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

endpackage

// File: rtl/sipo_deserializer_thermo_decode.sv
// Combinational thermometer decoder: reports whether a word has the shape
// 1..10..0 (all-0 and all-1 included) and how many leading ones it has.
module thermo_decode #(
  parameter int WIDTH = 6,
  parameter int LENW  = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] word,
  output logic             is_thermo,
  output logic [LENW-1:0]  lead_len
);

  logic seen_zero;

  // Walk from the MSB: count ones until the first zero; any one after that breaks the pattern.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
    is_thermo = 1'b1;
    lead_len  = '0;
    seen_zero = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!word[i]) begin
        seen_zero = 1'b1;
      end else if (seen_zero) begin
        is_thermo = 1'b0;
      end else begin
        lead_len = lead_len + LENW'(1);
      end
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver. Bits arrive MSB-first on sin, qualified by
// sin_valid; each WIDTH-bit word lands in a single-entry output buffer with a
// valid/ready handshake, plus its thermometer decode.
// Optional feature: define PARITY_CHECK_EN to expect one even-parity bit after
// the data bits of every frame; mismatching frames are dropped with par_err.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH,
  parameter int LENW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_thermo,
  output logic [LENW-1:0]  out_len,
  output logic             busy,
  output logic             overrun,
  output logic             overrun_sticky,
  output logic             par_err
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [LENW-1:0]  cnt_q, cnt_d;
  logic             complete;
  logic [WIDTH-1:0] word;
  logic             par_fail;
  logic             dec_thermo;
  logic [LENW-1:0]  dec_len;

  // Frame state, shift register and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples the pre-edge values.
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: shift qualified bits in, flag a finished word (or a parity failure).
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    word     = shift_q;
    par_fail = 1'b0;
    case (state_q)
      IDLE: begin
        if (sin_valid) begin
          shift_d = {{(WIDTH-1){1'b0}}, sin};
          cnt_d   = LENW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          shift_d = {shift_q[WIDTH-2:0], sin};
          cnt_d   = cnt_q + LENW'(1);
          if (cnt_q == LENW'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
            state_d = PAR;
`else
            state_d  = IDLE;
            cnt_d    = '0;
            complete = 1'b1;
            word     = shift_d;
`endif
          end
        end
      end
      PAR: begin
`ifdef PARITY_CHECK_EN
        // Even parity: data bits plus parity bit must xor to zero.
        if (sin_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (^{shift_q, sin}) begin
            par_fail = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
`else
        state_d = IDLE;
        cnt_d   = '0;
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

  thermo_decode #(
    .WIDTH (WIDTH),
    .LENW  (LENW)
  ) u_thermo_decode (
    .word      (word),
    .is_thermo (dec_thermo),
    .lead_len  (dec_len)
  );

  // Single-entry output buffer: load on completion if empty or draining, else drop and flag overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the output buffer is reset too, because every output must read 0 straight out of reset.
      out_data       <= '0;
      out_valid      <= 1'b0;
      out_thermo     <= 1'b0;
      out_len        <= '0;
      overrun        <= 1'b0;
      overrun_sticky <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete && (!out_valid || out_ready)) begin
        out_data   <= word;
        out_thermo <= dec_thermo;
        out_len    <= dec_len;
        out_valid  <= 1'b1;
      end else begin
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
        if (complete) begin
          overrun        <= 1'b1;
          overrun_sticky <= 1'b1;
        end
      end
    end
  end

`ifdef PARITY_CHECK_EN
  // One-cycle parity error pulse, aligned with where the word would have appeared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err <= 1'b0;
    end else begin
      par_err <= par_fail;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer (WIDTH=6): directed frames with
// literal expectations, then randomized traffic against a bit-queue model.
// Honours PARITY_CHECK_EN when the bench is built with it.
module tb_sipo_deserializer;
  import sipo_pkg::*;

  localparam int W  = 6;
  localparam int LW = $clog2(W + 1);
`ifdef PARITY_CHECK_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          sin;
  logic          sin_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_thermo;
  logic [LW-1:0] out_len;
  logic          busy;
  logic          overrun;
  logic          overrun_sticky;
  logic          par_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .sin            (sin),
    .sin_valid      (sin_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_thermo     (out_thermo),
    .out_len        (out_len),
    .busy           (busy),
    .overrun        (overrun),
    .overrun_sticky (overrun_sticky),
    .par_err        (par_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            bits[$];
  logic          m_valid, m_thermo, m_ovr, m_sticky, m_perr;
  logic [W-1:0]  m_data;
  logic [LW-1:0] m_len;

  function automatic int lead_ones(input int w);
    int n = 0;
    while (n < W && ((w >> (W - 1 - n)) & 1) == 1) n++;
    return n;
  endfunction

  function automatic bit is_thermo(input int w);
    int n = lead_ones(w);
    int full = (1 << W) - 1;
    return w == (full & ~((1 << (W - n)) - 1));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bits.delete();
      m_valid = 0; m_thermo = 0; m_ovr = 0; m_sticky = 0; m_perr = 0;
      m_data = '0; m_len = '0;
    end else begin
      bit done;
      bit perr_now;
      int word;
      int ones;
      done = 0; perr_now = 0; word = 0; ones = 0;
      if (sin_valid) begin
        bits.push_back(int'(sin));
        if (bits.size() == FRAME) begin
          for (int i = 0; i < W; i++) word = word * 2 + bits[i];
          foreach (bits[i]) ones += bits[i];
          if (FRAME > W && (ones % 2) == 1) perr_now = 1;
          else done = 1;
          bits.delete();
        end
      end
      m_ovr  = 0;
      m_perr = perr_now;
      if (done && (!m_valid || out_ready)) begin
        m_valid  = 1;
        m_data   = W'(word);
        m_len    = LW'(lead_ones(word));
        m_thermo = is_thermo(word);
      end else begin
        if (m_valid && out_ready) m_valid = 0;
        if (done) begin
          m_ovr    = 1;
          m_sticky = 1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (!reset) begin
      check("valid", out_valid, m_valid);
      check("data", out_data, m_data);
      check("thermo", out_thermo, m_thermo);
      check("len", out_len, m_len);
      check("busy", busy, bits.size() != 0);
      check("overrun", overrun, m_ovr);
      check("sticky", overrun_sticky, m_sticky);
      check("par_err", par_err, m_perr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_frame(input logic [W-1:0] w, input bit gaps, input logic pbit);
    for (int i = W - 1; i >= 0; i--) begin
      @(negedge clk);
      sin = w[i];
      sin_valid = 1'b1;
      if (gaps && i > 0) begin
        repeat (1 + $urandom_range(0, 2)) begin
          @(negedge clk);
          sin_valid = 1'b0;
          sin = 1'($urandom);
          check("busy_gap", busy, 1);
        end
      end
    end
`ifdef PARITY_CHECK_EN
    @(negedge clk);
    sin = pbit;
    sin_valid = 1'b1;
`else
    if (pbit === 1'bx) $display("parity bit unused");
`endif
  endtask

  task automatic finish_frame();
    @(negedge clk);
    sin_valid = 1'b0;
  endtask

  task automatic expect_word(input string name, input logic [W-1:0] d, input logic th, input logic [LW-1:0] ln);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"}, out_data, d);
    check({name, "_thermo"}, out_thermo, th);
    check({name, "_len"}, out_len, ln);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sin = 1'b0; sin_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_sticky", overrun_sticky, 0);
    reset = 1'b0;

    // 1: contiguous thermometer word, visible exactly one cycle after the last bit.
    out_ready = 1'b1;
    send_frame(6'b111000, 0, 1'b1);
    check("t1_not_yet", out_valid, 0);
    finish_frame();
    expect_word("t1", 6'b111000, 1, 3);
    check("model_t1_len", m_len, 3);

    // 2: gapped non-thermometer word.
    repeat (2) @(negedge clk);
    send_frame(6'b101100, 1, 1'b1);
    finish_frame();
    expect_word("t2", 6'b101100, 0, 1);
    check("model_t2_thermo", m_thermo, 0);

    // 3: consumer stalled, second word dropped with overrun.
    @(negedge clk);
    out_ready = 1'b0;
    send_frame(6'b111111, 0, 1'b0);
    send_frame(6'b000000, 0, 1'b0);
    finish_frame();
    expect_word("t3", 6'b111111, 1, 6);
    check("t3_overrun", overrun, 1);
    check("t3_sticky", overrun_sticky, 1);
    @(negedge clk);
    check("t3_overrun_gone", overrun, 0);
    check("t3_sticky_held", overrun_sticky, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_drained", out_valid, 0);
    check("t3_data_kept", out_data, 6'b111111);

    // 4: completion coincides with acceptance, out_valid stays high.
    send_frame(6'b110000, 0, 1'b0);
    finish_frame();
    expect_word("t4a", 6'b110000, 1, 2);
    out_ready = 1'b0;
    send_frame(6'b111110, 0, 1'b1);
    check("t4_held", out_valid, 1);
    check("t4_held_data", out_data, 6'b110000);
    out_ready = 1'b1;
    finish_frame();
    expect_word("t4b", 6'b111110, 1, 5);
    check("t4_no_overrun", overrun, 0);

    // 5: asynchronous reset mid-frame, then a clean frame.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sin = 1'b1;
      sin_valid = 1'b1;
    end
    @(negedge clk);
    sin_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t5_valid", out_valid, 0);
    check("t5_data", out_data, 0);
    check("t5_len", out_len, 0);
    check("t5_busy", busy, 0);
    check("t5_sticky", overrun_sticky, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    send_frame(6'b100000, 0, 1'b1);
    finish_frame();
    expect_word("t5", 6'b100000, 1, 1);

`ifdef PARITY_CHECK_EN
    // 6: even parity over 6'b111000 plus parity bit: p=0 leaves an odd count (error), p=1 matches.
    repeat (3) @(negedge clk);
    send_frame(6'b111000, 0, 1'b0);
    finish_frame();
    check("t6_par_err", par_err, 1);
    check("t6_no_word", out_valid, 0);
    @(negedge clk);
    check("t6_par_err_gone", par_err, 0);
    send_frame(6'b111000, 0, 1'b1);
    finish_frame();
    check("t6_no_par_err", par_err, 0);
    expect_word("t6", 6'b111000, 1, 3);
`endif

    // Randomized traffic against the model.
    repeat (3000) begin
      @(negedge clk);
      sin       = 1'($urandom);
      sin_valid = ($urandom_range(0, 9) < 6);
      out_ready = 1'($urandom);
    end
    @(negedge clk);
    sin_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
